// File: rtl/demux_router.sv
// demux_router: routes a single valid/ready word stream into one of two
// independent sink FIFOs chosen by a per-word select bit, with per-sink
// delivery counters for debug.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. A producer holding valid must keep its payload (and in_sel) stable
// until that edge. in_ready depends only on in_sel and registered FIFO
// occupancy, never on either sink's ready, so no ready pass-through exists.
module demux_router #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [WIDTH-1:0]     out0_data,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [WIDTH-1:0]     out1_data,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  // Index 0 is sink 0, index 1 is sink 1 throughout.
  logic [1:0][DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [1:0][PW-1:0]               wptr_q, wptr_d;
  logic [1:0][PW-1:0]               rptr_q, rptr_d;
  logic [1:0][PW:0]                 count_q, count_d;
  logic [1:0][CNT_WIDTH-1:0]        dcnt_q, dcnt_d;

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] sink_ready;
  logic       accept;

  // Status flags and handshake decode for both FIFOs.
  always_comb begin
    sink_ready = {out1_ready, out0_ready};
    for (int n = 0; n < 2; n++) begin
      full[n]  = (count_q[n] == FULL_CNT);
      empty[n] = (count_q[n] == '0);
      pop[n]   = !empty[n] && sink_ready[n];
    end
    in_ready = in_sel ? !full[1] : !full[0];
    accept   = in_valid && in_ready;
    push[0]  = accept && !in_sel;
    push[1]  = accept && in_sel;
  end

  // Next-state for storage, pointers, occupancy and delivery counters.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dcnt_d  = dcnt_q;
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        mem_d[n][wptr_q[n]] = in_data;
        wptr_d[n]           = wptr_q[n] + PW'(1);
      end
      if (pop[n]) begin
        rptr_d[n] = rptr_q[n] + PW'(1);
        dcnt_d[n] = dcnt_q[n] + CNT_WIDTH'(1);
      end
      // Push and pop together leave occupancy unchanged.
      count_d[n] = count_q[n] + (PW+1)'(push[n]) - (PW+1)'(pop[n]);
    end
  end

  // State registers; reset drops buffered words and clears storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dcnt_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Sink outputs come straight from registered state.
  always_comb begin
    out0_valid = !empty[0];
    out1_valid = !empty[1];
    out0_data  = mem_q[0][rptr_q[0]];
    out1_data  = mem_q[1][rptr_q[1]];
    cnt0       = dcnt_q[0];
    cnt1       = dcnt_q[1];
  end

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: directed vector table, randomized traffic against
// a queue-based reference model, a long counter-wrap stream and a
// mid-traffic asynchronous reset.
module tb_demux_router;

  localparam int W     = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sel;
  logic [W-1:0]  in_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [W-1:0]  out0_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [W-1:0]  out1_data;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  demux_router #(.WIDTH(W), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: one queue of expected words per sink plus counters
  logic [W-1:0]  exp0_q[$];
  logic [W-1:0]  exp1_q[$];
  logic [CW-1:0] m_cnt0;
  logic [CW-1:0] m_cnt1;
  logic          last_acc;

  typedef struct {
    logic          v;
    logic          s;
    logic [W-1:0]  d;
    logic          r0;
    logic          r1;
    logic          e_rdy;
    logic          e_v0;
    logic          e_v1;
    logic [W-1:0]  e_d0;
    logic [W-1:0]  e_d1;
    logic [CW-1:0] e_c0;
    logic [CW-1:0] e_c1;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp0_q.delete();
    exp1_q.delete();
    m_cnt0 = '0;
    m_cnt1 = '0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic model_cycle();
    logic e_rdy;
    #1;
    e_rdy = in_sel ? (exp1_q.size() < DEPTH) : (exp0_q.size() < DEPTH);
    chk("in_ready", in_ready, e_rdy);
    chk("out0_valid", out0_valid, exp0_q.size() > 0);
    chk("out1_valid", out1_valid, exp1_q.size() > 0);
    if (exp0_q.size() > 0) chk("out0_data", out0_data, exp0_q[0]);
    if (exp1_q.size() > 0) chk("out1_data", out1_data, exp1_q[0]);
    chk("cnt0", cnt0, m_cnt0);
    chk("cnt1", cnt1, m_cnt1);
    last_acc = in_valid && e_rdy;
    if (out0_ready && exp0_q.size() > 0) begin
      void'(exp0_q.pop_front());
      m_cnt0++;
    end
    if (out1_ready && exp1_q.size() > 0) begin
      void'(exp1_q.pop_front());
      m_cnt1++;
    end
    if (last_acc) begin
      if (in_sel) exp1_q.push_back(in_data);
      else        exp0_q.push_back(in_data);
    end
    @(negedge clk);
  endtask

  task automatic drive_idle();
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    in_sel = 1'b0;
    #1;
    chk({tag, "_in_ready_sel0"}, in_ready, 1'b1);
    in_sel = 1'b1;
    #1;
    chk({tag, "_in_ready_sel1"}, in_ready, 1'b1);
    chk({tag, "_out0_valid"}, out0_valid, 1'b0);
    chk({tag, "_out1_valid"}, out1_valid, 1'b0);
    chk({tag, "_cnt0"}, cnt0, 16'd0);
    chk({tag, "_cnt1"}, cnt1, 16'd0);
    chk({tag, "_out0_data"}, out0_data, 32'd0);
    chk({tag, "_out1_data"}, out1_data, 32'd0);
  endtask

  initial begin
    int accepted;
    int cycles;

    // basic routing, backpressure/isolation, full with simultaneous pop
    vecs[0]  = '{1, 0, 32'hAAAA0001, 1, 1, 1, 0, 0, 32'h0,        32'h0,        16'd0, 16'd0};
    vecs[1]  = '{1, 1, 32'hBBBB0002, 1, 1, 1, 1, 0, 32'hAAAA0001, 32'h0,        16'd0, 16'd0};
    vecs[2]  = '{0, 0, 32'h0,        1, 1, 1, 0, 1, 32'h0,        32'hBBBB0002, 16'd1, 16'd0};
    vecs[3]  = '{0, 0, 32'h0,        1, 1, 1, 0, 0, 32'h0,        32'h0,        16'd1, 16'd1};
    vecs[4]  = '{1, 0, 32'h11110001, 0, 1, 1, 0, 0, 32'h0,        32'h0,        16'd1, 16'd1};
    vecs[5]  = '{1, 0, 32'h11110002, 0, 1, 1, 1, 0, 32'h11110001, 32'h0,        16'd1, 16'd1};
    vecs[6]  = '{1, 0, 32'h11110003, 0, 1, 0, 1, 0, 32'h11110001, 32'h0,        16'd1, 16'd1};
    vecs[7]  = '{0, 1, 32'h0,        0, 1, 1, 1, 0, 32'h11110001, 32'h0,        16'd1, 16'd1};
    vecs[8]  = '{1, 1, 32'h22220001, 0, 1, 1, 1, 0, 32'h11110001, 32'h0,        16'd1, 16'd1};
    vecs[9]  = '{1, 0, 32'h11110003, 0, 1, 0, 1, 1, 32'h11110001, 32'h22220001, 16'd1, 16'd1};
    vecs[10] = '{1, 0, 32'h11110003, 1, 1, 0, 1, 0, 32'h11110001, 32'h0,        16'd1, 16'd2};
    vecs[11] = '{1, 0, 32'h11110003, 1, 1, 1, 1, 0, 32'h11110002, 32'h0,        16'd2, 16'd2};
    vecs[12] = '{0, 0, 32'h0,        1, 1, 1, 1, 0, 32'h11110003, 32'h0,        16'd3, 16'd2};
    vecs[13] = '{0, 0, 32'h0,        1, 1, 1, 0, 0, 32'h0,        32'h0,        16'd4, 16'd2};

    // reset, then check the released state
    rst_n = 1'b0;
    drive_idle();
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("reset");
    @(negedge clk);

    // directed vector table
    for (int i = 0; i < 14; i++) begin
      in_valid   = vecs[i].v;
      in_sel     = vecs[i].s;
      in_data    = vecs[i].d;
      out0_ready = vecs[i].r0;
      out1_ready = vecs[i].r1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_out0_valid", i), out0_valid, vecs[i].e_v0);
      chk($sformatf("vec%0d_out1_valid", i), out1_valid, vecs[i].e_v1);
      if (vecs[i].e_v0) chk($sformatf("vec%0d_out0_data", i), out0_data, vecs[i].e_d0);
      if (vecs[i].e_v1) chk($sformatf("vec%0d_out1_data", i), out1_data, vecs[i].e_d1);
      chk($sformatf("vec%0d_cnt0", i), cnt0, vecs[i].e_c0);
      chk($sformatf("vec%0d_cnt1", i), cnt1, vecs[i].e_c1);
      @(negedge clk);
    end

    // randomized traffic against the reference model
    do_reset();
    last_acc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      // a word that was offered and not taken stays on the bus unchanged
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      model_cycle();
    end

    // long stream to sink 1: counter wrap and full throughput
    do_reset();
    in_valid   = 1'b1;
    in_sel     = 1'b1;
    in_data    = $urandom;
    out1_ready = 1'b1;
    accepted   = 0;
    cycles     = 0;
    while (accepted < 65537 && cycles < 70000) begin
      out0_ready = 1'($urandom_range(0, 1));
      model_cycle();
      cycles++;
      if (last_acc) begin
        accepted++;
        in_data = $urandom;
      end
    end
    chk("stream_accepted", accepted, 65537);
    chk("stream_cycles", cycles, 65537);
    in_valid = 1'b0;
    repeat (2) model_cycle();
    chk("stream_cnt1_wrapped", cnt1, 16'd1);

    // fill both FIFOs with 2 words, then assert reset mid-cycle
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel   = 1'(i % 2);
      in_data  = $urandom;
      model_cycle();
    end
    in_valid = 1'b0;
    #1;
    chk("pre_reset_out0_valid", out0_valid, 1'b1);
    chk("pre_reset_out1_valid", out1_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    check_reset_values("midrst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (4) model_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_router.md
# demux_router

Routes one 32-bit data stream to one of two sinks based on a per-word select bit, the demultiplexing counterpart to the datapath's 2:1 select mux. Each sink has its own small FIFO with a valid/ready handshake, so a stalled sink does not block words sent to the other sink. It sits between a single result producer (for example, a writeback/result bus) and two independent consumers. Per-sink delivery counters support debug and verification.

## Interface
Parameters:
- `WIDTH`, 32: data width in bits.
- `DEPTH`, 2: entries per sink FIFO; must be a power of two and at least 2.
- `CNT_WIDTH`, 16: width of the delivery counters.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to `clk`.
- `in_valid`, in, 1: producer has a word.
- `in_ready`, out, 1: the router can accept the word.
- `in_sel`, in, 1: destination; 0 selects sink 0, 1 selects sink 1.
- `in_data`, in, WIDTH: word to route.
- `out0_valid`, out, 1: sink 0 FIFO is non-empty.
- `out0_ready`, in, 1: sink 0 consumes its head word.
- `out0_data`, out, WIDTH: sink 0 head word.
- `out1_valid`, out, 1: sink 1 FIFO is non-empty.
- `out1_ready`, in, 1: sink 1 consumes its head word.
- `out1_data`, out, WIDTH: sink 1 head word.
- `cnt0`, out, CNT_WIDTH: number of words delivered on sink 0.
- `cnt1`, out, CNT_WIDTH: number of words delivered on sink 1.

## Operation
- **Per-sink FIFO.** Each sink has a circular buffer of `DEPTH` entries.
  - State: write pointer, read pointer, and an occupancy count from 0 to DEPTH.
  - `full` means count == DEPTH; `empty` means count == 0.
- **Accept.** A word is accepted when `in_valid && in_ready`.
  - `in_ready = !full[in_sel]`. This depends combinationally on `in_sel` and on registered state only. It never depends on `outN_ready`.
  - An accepted word is written to the FIFO for sink `in_sel`.
  - The other FIFO is untouched.
- **Deliver.** Sink N pops its head when `outN_valid && outN_ready`.
  - `outN_valid = !empty[N]`.
  - `outN_data` is the entry at the read pointer.
- **Simultaneous push and pop on one FIFO.**
  - When not full, both take effect and the count is unchanged.
  - When full, only the pop happens, because `in_ready` was already 0. There is no ready pass-through.
  - When empty, there is no pop, since valid is 0. The push lands, and the word is visible the next cycle.
- **Concurrent pops.** Sinks 0 and 1 may pop in the same cycle. A push to one FIFO may coincide with a pop on the other.
- **Pointer wrap.** Pointers wrap modulo DEPTH.
- **Ordering.** Order is preserved per sink. There is no ordering relation between sinks.
- **Counters.** `cntN` increments by 1 on each pop of sink N and wraps from 2^CNT_WIDTH−1 to 0.
- **No-transfer cycles.** When `in_valid` is 0, or `in_valid` is 1 and `in_ready` is 0, no state changes on the input side. The producer must hold `in_sel` and `in_data` stable until the word is accepted.
- **Reset values.**
  - All pointers and counts are 0.
  - `out0_valid` = `out1_valid` = 0; `cnt0` = `cnt1` = 0.
  - Storage is cleared to 0, so `out0_data` = `out1_data` = 0.
  - `in_ready` = 1 for either `in_sel`.
- **Reset mid-operation.** Assertion drops all buffered words and zeroes the counters asynchronously. No partial transfer completes.

## Timing
- **Latency.** A word accepted at edge k appears on `outN_valid`/`outN_data` after edge k, and is poppable at edge k+1. This is a 1-cycle latency.
- **Throughput.** One word per cycle into each sink, provided the sink pops every cycle. Sustained rate with a continuously ready sink is 1 word/cycle at DEPTH ≥ 2.
- **Data when idle.** `outN_data` when `outN_valid` = 0 is the stale storage entry. Consumers must ignore it.
- **Combinational paths.** The only combinational input-to-output path is `in_sel` → `in_ready`. All other outputs are register-driven.

## Test plan
- **Reset.** Hold `rst_n` = 0, then release. Check `in_ready` = 1, both valids = 0, both counts = 0, and both data outputs = 0.
- **Basic routing.** Send 0xAAAA0001 with sel 0 and 0xBBBB0002 with sel 1, both sinks ready.
  - `out0_data` = 0xAAAA0001 one cycle after its accept; `out1_data` = 0xBBBB0002 one cycle after its accept.
  - Afterwards `cnt0` = `cnt1` = 1.
- **Backpressure and isolation.** Hold `out0_ready` = 0 and push 3 words with sel 0.
  - After 2 accepts, `in_ready` = 0 with sel 0 while staying 1 with sel 1.
  - Pushes to sink 1 continue to be delivered.
  - Then release `out0_ready`: the sink 0 words emerge in order 1, 2, 3.
- **Full plus simultaneous pop.** With sink 0 full and `out0_ready` = 1, present sel 0.
  - `in_ready` is 0 that cycle.
  - The next cycle count = 1 and `in_ready` = 1. There is no word loss or duplication.
- **Counter wrap and stream.** Stream 65537 words with sel 1, sink always ready.
  - `cnt1` wraps to 1.
  - All data matches a scoreboard, and throughput is 1 word/cycle after the first.
- **Reset mid-stream.** Assert `rst_n` while both FIFOs hold 2 words. Outputs immediately return to reset values, and no stale word appears after release.
